// File: rtl/bpu_btb_bht_pkg.sv
// Shared constants and helpers for the branch prediction unit.
package bpu_btb_bht_pkg;

  // Sequential fetch advances by one 32-bit instruction.
  localparam logic [31:0] PC_INC = 32'd4;

  // Kind of table write requested by the EX-stage update port.
  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_TRAIN,
    UPD_ALLOC
  } upd_kind_e;

  // Index width for a power-of-two entry count.
  function automatic int idx_bits(input int entries);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < entries) n = i + 1;
    end
    return n;
  endfunction

  // Tag covers PC[31:IDX+2].
  function automatic int tag_bits(input int entries);
    return 30 - idx_bits(entries);
  endfunction

  // Weakly-taken counter value: MSB set, remaining bits clear.
  function automatic logic [3:0] weak_taken_init(input int ctr_bits);
    return 4'(1 << (ctr_bits - 1));
  endfunction

endpackage

// File: rtl/bpu_btb_bht_sat_ctr.sv
// Saturating up/down next-state logic for one direction counter.
module bpu_sat_ctr #(
  parameter int W = 2
) (
  input  logic [W-1:0] ctr,
  input  logic         inc,
  output logic [W-1:0] ctr_nxt
);

  // Step toward taken or not-taken, holding at the extremes.
  always_comb begin
    ctr_nxt = ctr;
    if (inc) begin
      if (ctr != '1) ctr_nxt = ctr + W'(1);
    end else begin
      if (ctr != '0) ctr_nxt = ctr - W'(1);
    end
  end

endmodule

// File: rtl/bpu_btb_bht.sv
// Direct-mapped BTB with per-entry saturating direction counters and
// saturating branch/mispredict statistics.
module bpu_btb_bht
  import bpu_btb_bht_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       rd_PC,
  output logic              rd_predicted,
  output logic [31:0]       rd_predicted_PC,
  input  logic              upd_valid,
  input  logic [31:0]       upd_PC,
  input  logic [31:0]       upd_target,
  input  logic              upd_taken,
  input  logic              upd_predicted,
  input  logic              flush_all,
  input  logic              stat_clr,
  output logic              upd_mispredict,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX   = idx_bits(ENTRIES);
  localparam int TAG_W = tag_bits(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(weak_taken_init(CTR_BITS));

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [TAG_W-1:0]    tag_d    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [31:0]         target_d [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d    [ENTRIES];
  logic [STAT_W-1:0]   stat_branches_q, stat_branches_d;
  logic [STAT_W-1:0]   stat_mispredicts_q, stat_mispredicts_d;

  logic [IDX-1:0]      rd_idx, upd_idx;
  logic [TAG_W-1:0]    rd_tag, upd_tag;
  logic                rd_hit, upd_hit;
  logic [CTR_BITS-1:0] upd_ctr_trained;
  upd_kind_e           upd_kind;
  logic [3:0]          pc_unused_bits;

  assign rd_idx  = rd_PC[IDX+1:2];
  assign rd_tag  = rd_PC[31:IDX+2];
  assign upd_idx = upd_PC[IDX+1:2];
  assign upd_tag = upd_PC[31:IDX+2];
  assign pc_unused_bits = {rd_PC[1:0], upd_PC[1:0]};

  // Fetch-side lookup: purely combinational, sees only committed state.
  always_comb begin
    rd_hit          = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_predicted    = rd_hit && ctr_q[rd_idx][CTR_BITS-1];
    rd_predicted_PC = rd_predicted ? target_q[rd_idx] : rd_PC + PC_INC;
    upd_hit         = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_mispredict  = upd_valid && (upd_taken ^ upd_predicted);
  end

  bpu_sat_ctr #(.W(CTR_BITS)) u_sat_ctr (
    .ctr     (ctr_q[upd_idx]),
    .inc     (upd_taken),
    .ctr_nxt (upd_ctr_trained)
  );

  // Classify the update; a flush drops any concurrent training.
  always_comb begin
    upd_kind = UPD_NONE;
    if (upd_valid && !flush_all) begin
      if (upd_hit)        upd_kind = UPD_TRAIN;
      else if (upd_taken) upd_kind = UPD_ALLOC;
    end
  end

  // Next table contents: one entry written per cycle, or all invalidated.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (flush_all) valid_d = '0;
    case (upd_kind)
      UPD_TRAIN: begin
        ctr_d[upd_idx] = upd_ctr_trained;
        if (upd_taken) target_d[upd_idx] = upd_target;
      end
      UPD_ALLOC: begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = CTR_WEAK;
      end
      default: ;
    endcase
  end

  // Next statistics: clear beats increment, both saturate at all-ones.
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (stat_clr) begin
      stat_branches_d    = '0;
      stat_mispredicts_d = '0;
    end else if (upd_valid) begin
      if (stat_branches_q != '1) stat_branches_d = stat_branches_q + STAT_W'(1);
      if (upd_mispredict && (stat_mispredicts_q != '1))
        stat_mispredicts_d = stat_mispredicts_q + STAT_W'(1);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q            <= '0;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else begin
      valid_q            <= valid_d;
      tag_q              <= tag_d;
      target_q           <= target_d;
      ctr_q              <= ctr_d;
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_bpu_btb_bht.sv
// Scoreboard bench for bpu_btb_bht with 4-bit statistics counters.
module tb_bpu_btb_bht;

  logic        clk;
  logic        rst;
  logic [31:0] rdPc;
  logic        rdPredicted;
  logic [31:0] rdPredictedPc;
  logic        updValid;
  logic [31:0] updPc;
  logic [31:0] updTarget;
  logic        updTaken;
  logic        updPredicted;
  logic        flushAll;
  logic        statClr;
  logic        updMispredict;
  logic [3:0]  statBranches;
  logic [3:0]  statMispredicts;

  typedef struct {
    string       name;
    logic        pred;
    logic [31:0] pc;
    logic        mis;
    logic [3:0]  br;
    logic [3:0]  mp;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   numTests = 0;
  int   numFails = 0;

  bpu_btb_bht #(.ENTRIES(64), .CTR_BITS(2), .STAT_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .rd_PC            (rdPc),
    .rd_predicted     (rdPredicted),
    .rd_predicted_PC  (rdPredictedPc),
    .upd_valid        (updValid),
    .upd_PC           (updPc),
    .upd_target       (updTarget),
    .upd_taken        (updTaken),
    .upd_predicted    (updPredicted),
    .flush_all        (flushAll),
    .stat_clr         (statClr),
    .upd_mispredict   (updMispredict),
    .stat_branches    (statBranches),
    .stat_mispredicts (statMispredicts)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed field against its expected value.
  task automatic checkOutput(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
    numTests++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the response expected mid-cycle.
  task automatic applyStimulus(input string name, input logic [31:0] pc,
                               input logic uv, input logic [31:0] upc,
                               input logic [31:0] utgt, input logic ut,
                               input logic up, input logic fl, input logic clr,
                               input logic ePred, input logic [31:0] ePc,
                               input logic eMis, input logic [3:0] eBr,
                               input logic [3:0] eMp);
    exp_t e;
    rdPc = pc; updValid = uv; updPc = upc; updTarget = utgt;
    updTaken = ut; updPredicted = up; flushAll = fl; statClr = clr;
    e.name = name; e.pred = ePred; e.pc = ePc; e.mis = eMis; e.br = eBr; e.mp = eMp;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare on the falling edge, away from state updates.
  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      cur = expQ.pop_front();
      checkOutput(cur.name, "pred",  32'(rdPredicted),     32'(cur.pred));
      checkOutput(cur.name, "npc",   rdPredictedPc,        cur.pc);
      checkOutput(cur.name, "mis",   32'(updMispredict),   32'(cur.mis));
      checkOutput(cur.name, "br",    32'(statBranches),    32'(cur.br));
      checkOutput(cur.name, "mp",    32'(statMispredicts), 32'(cur.mp));
    end
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    int br;
    int mp;
    rst = 1'b1; rdPc = '0; updValid = 0; updPc = '0; updTarget = '0;
    updTaken = 0; updPredicted = 0; flushAll = 0; statClr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //             name        rdPC       uv updPC      tgt        t  p  fl clr  pred npc        mis br mp
    applyStimulus("reset",    32'h100, 0, 32'h0,   32'h0,    0, 0, 0, 0,  0, 32'h104, 0, 0, 0);
    applyStimulus("nobypass", 32'h100, 1, 32'h100, 32'h80,   1, 0, 0, 0,  0, 32'h104, 1, 0, 0);
    applyStimulus("alloc",    32'h100, 1, 32'h100, 32'h500,  0, 1, 0, 0,  1, 32'h80,  1, 1, 1);
    applyStimulus("ctr1",     32'h100, 1, 32'h100, 32'h500,  0, 1, 0, 0,  0, 32'h104, 1, 2, 2);
    applyStimulus("ctr0",     32'h100, 1, 32'h100, 32'h80,   1, 0, 0, 0,  0, 32'h104, 1, 3, 3);
    applyStimulus("ctrUp1",   32'h100, 1, 32'h100, 32'h80,   1, 0, 0, 0,  0, 32'h104, 1, 4, 4);
    applyStimulus("ctrUp2",   32'h100, 0, 32'h0,   32'h0,    0, 0, 0, 0,  1, 32'h80,  0, 5, 5);
    applyStimulus("aliasMiss",32'h200, 0, 32'h0,   32'h0,    0, 0, 0, 0,  0, 32'h204, 0, 5, 5);
    applyStimulus("aliasUpd", 32'h200, 1, 32'h200, 32'h300,  1, 1, 0, 0,  0, 32'h204, 0, 5, 5);
    applyStimulus("aliasHit", 32'h200, 0, 32'h0,   32'h0,    0, 0, 0, 0,  1, 32'h300, 0, 6, 5);
    applyStimulus("evicted",  32'h100, 0, 32'h0,   32'h0,    0, 0, 0, 0,  0, 32'h104, 0, 6, 5);
    applyStimulus("ntMiss",   32'h40,  1, 32'h40,  32'h900,  0, 0, 0, 0,  0, 32'h44,  0, 6, 5);
    applyStimulus("ntNoAlloc",32'h40,  0, 32'h0,   32'h0,    0, 0, 0, 0,  0, 32'h44,  0, 7, 5);
    applyStimulus("flush",    32'h200, 1, 32'h140, 32'h1000, 1, 0, 1, 0,  1, 32'h300, 1, 7, 5);
    applyStimulus("flushMiss",32'h200, 0, 32'h0,   32'h0,    0, 0, 0, 0,  0, 32'h204, 0, 8, 6);
    applyStimulus("flushDrop",32'h140, 0, 32'h0,   32'h0,    0, 0, 0, 0,  0, 32'h144, 0, 8, 6);
    applyStimulus("pcWrap",   32'hFFFFFFFC, 0, 32'h0, 32'h0, 0, 0, 0, 0,  0, 32'h0,   0, 8, 6);

    for (int i = 0; i < 20; i++) begin
      br = (8 + i > 15) ? 15 : 8 + i;
      mp = (6 + i > 15) ? 15 : 6 + i;
      applyStimulus("satRun", 32'h600, 1, 32'h500, 32'h700, 0, 1, 0, 0,
                    0, 32'h604, 1, 4'(br), 4'(mp));
    end

    applyStimulus("satHold",  32'h600, 1, 32'h500, 32'h700,  0, 1, 0, 1,  0, 32'h604, 1, 15, 15);
    applyStimulus("clrWins",  32'h600, 0, 32'h0,   32'h0,    0, 0, 0, 0,  0, 32'h604, 0, 0, 0);
    applyStimulus("realloc",  32'h100, 1, 32'h100, 32'h80,   1, 0, 0, 0,  0, 32'h104, 1, 0, 0);
    applyStimulus("reallocHit",32'h100,0, 32'h0,   32'h0,    0, 0, 0, 0,  1, 32'h80,  0, 1, 1);

    rst = 1'b1;
    applyStimulus("rstAsync", 32'h100, 1, 32'h200, 32'h300,  1, 0, 0, 0,  0, 32'h104, 1, 0, 0);
    rst = 1'b0;
    applyStimulus("rstDrop",  32'h200, 0, 32'h0,   32'h0,    0, 0, 0, 0,  0, 32'h204, 0, 0, 0);

    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge clk);
    numTests++;
    if (expQ.size() != 0) begin
      numFails++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", numTests, numFails);
    $finish;
  end

  logic unusedTb;
  assign unusedTb = 1'b0;

endmodule
